pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It owns the per-stage stall vector that freezes pc_reg, if_id, id_ex, ex_mem and mem_wb, and it owns the flush/redirect sequence taken on an exception or ERET. Stage stall requests and the MEM-stage exception report feed into it. Its outputs fan out to every pipeline register and to the PC generator.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0020: redirect target for any exception other than ERET.
- HOLD_CYCLES, 3: cycles after a flush during which new exception reports are ignored. Range 1..15.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stallreq_if  in  1  fetch waiting on the instruction bus.
- stallreq_id  in  1  load-use hazard in decode.
- stallreq_ex  in  1  multi-cycle EX operation (mult/div) busy.
- excepttype_i  in  32  MEM-stage exception code; 0 means none; 32'h0000_000e means ERET.
- cp0_epc_i  in  32  current EPC from CP0.
- stall  out  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb. A set bit holds that stage.
- flush  out  1  registered flush pulse to all pipeline registers.
- new_pc  out  32  registered redirect address; valid only while flush=1.

## Operation
- FSM states: RUN, FLUSH, HOLD. Reset state is RUN.
- RUN:
  - excepttype_i != 0: stall = 6'b111111 in this cycle; latch the target; next state FLUSH.
  - Otherwise stall comes from the priority encode, highest stage first:
    - stallreq_ex gives 6'b001111.
    - stallreq_id gives 6'b000111.
    - stallreq_if gives 6'b000011.
    - No request gives 6'b000000.
- Target selection:
  - excepttype_i == 32'h0000_000e: cp0_epc_i.
  - Any other nonzero code: EXC_VECTOR.
- FLUSH (always exactly one cycle):
  - flush = 1, new_pc = latched target, stall = 0.
  - Stall requests and exceptions are ignored.
  - Next state HOLD, with the hold counter loaded to HOLD_CYCLES.
- HOLD:
  - Stall requests are obeyed using the same encode as RUN.
  - excepttype_i is ignored, because it comes from squashed wrong-path instructions.
  - The counter decrements each cycle. At 1 the next state is RUN.

## Timing
- Reset values, applied asynchronously: stall = 0, flush = 0, new_pc = 32'h0, state RUN, hold counter 0, latched target 0.
- stall is combinational from the request inputs and state. Zero-cycle latency.
- flush and new_pc are registered. flush rises exactly one cycle after the cycle in which an exception was seen in RUN, and lasts 1 cycle.
- Exception and stall request in the same RUN cycle: the exception wins and stall = 6'b111111.
- An exception held asserted across the FLUSH and HOLD cycles produces exactly one flush.
- A new exception is accepted in the first RUN cycle after HOLD ends.
- rst asserted during FLUSH or HOLD:
  - Immediately return to RUN with all outputs cleared.
  - No pending flush survives reset.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Adds output stall_cnt (32), which increments in every cycle where stall != 0.
  - Adds output flush_cnt (16), which increments on every flush pulse.
  - Both counters saturate at all-ones and reset to 0.
- PIPE_CTRL_PERF_EN undefined: the ports and counters are absent. Core behaviour is identical.

## Structure
- The shared defines file gains:
  - StallBus (5:0).
  - Stall encodings StallNone, StallIf, StallId, StallEx, StallAll.
  - ExcEret = 32'h0000_000e.
  - Existing ZeroWord, InstAddrBus and RstEnable are reused.
- One sub-module, pipe_stall_enc: a combinational priority encoder from the three requests to the 6-bit vector.
- The FSM, target latch, hold counter and perf counters stay in pipe_ctrl.

## Test plan
- stallreq_id=1 alone in RUN -> stall=6'b000111 in the same cycle. With stallreq_ex=1 also set -> 6'b001111.
- excepttype_i=32'h1 for one cycle in RUN -> that cycle stall=6'b111111. Next cycle flush=1, new_pc=32'h20, stall=0. Following cycle flush=0.
- excepttype_i=32'h0000_000e with cp0_epc_i=32'h0000_1234 -> one cycle later flush=1, new_pc=32'h0000_1234.
- excepttype_i held at 32'h1 for 6 cycles, HOLD_CYCLES=3 -> exactly one flush. A second flush occurs only after the HOLD period ends and RUN is re-entered.
- rst pulsed asynchronously during HOLD with stallreq_ex=1 -> outputs cleared at once, state RUN. After release, stall=6'b001111 and no flush.
- With PIPE_CTRL_PERF_EN: 4 stall cycles and 2 exceptions -> stall_cnt counts the stall cycles (the 2 exception-cycle freezes are counted as stalls), flush_cnt=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall bus
// encodings, exception codes and FSM state type.
package pipe_ctrl_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam int          InstAddrBus = 32;
    localparam logic [31:0] ExcEret     = 32'h0000_000e;

    // StallBus is bits 5:0: pc, if_id, id_ex, ex_mem, mem_wb, wb.
    typedef logic [5:0] stall_bus_t;
    typedef logic [InstAddrBus-1:0] inst_addr_t;

    localparam stall_bus_t StallNone = 6'b000000;
    localparam stall_bus_t StallIf   = 6'b000011;
    localparam stall_bus_t StallId   = 6'b000111;
    localparam stall_bus_t StallEx   = 6'b001111;
    localparam stall_bus_t StallAll  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_HOLD
    } pipe_state_e;

    function automatic inst_addr_t redirect_target(input logic [31:0] exc_code,
                                                   input inst_addr_t  epc,
                                                   input inst_addr_t  vector);
        return (exc_code == ExcEret) ? epc : vector;
    endfunction

endpackage

// File: rtl/pipe_stall_enc.sv
// Priority encoder from the three stage stall requests to the stall bus;
// the deepest requesting stage wins because it must freeze everything ahead.
module pipe_stall_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_if,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    output logic [5:0] stall_o
);

    always_comb begin
        stall_o = StallNone;
        if (stallreq_ex) begin
            stall_o = StallEx;
        end else if (stallreq_id) begin
            stall_o = StallId;
        end else if (stallreq_if) begin
            stall_o = StallIf;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector, exception flush/redirect FSM.
// Optional perf counters (stall_cnt, flush_cnt) when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int          HOLD_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES);

    pipe_state_e state_q, state_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    inst_addr_t  target_q, target_d;
    logic        flush_q, flush_d;
    stall_bus_t  enc_stall;
    stall_bus_t  stall_c;

    pipe_stall_enc u_stall_enc (
        .stallreq_if (stallreq_if),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stall_o     (enc_stall)
    );

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        target_d   = target_q;
        flush_d    = 1'b0;
        stall_c    = StallNone;
        unique case (state_q)
            ST_RUN: begin
                if (excepttype_i != ZeroWord) begin
                    stall_c  = StallAll;
                    target_d = redirect_target(excepttype_i, cp0_epc_i, EXC_VECTOR);
                    flush_d  = 1'b1;
                    state_d  = ST_FLUSH;
                end else begin
                    stall_c = enc_stall;
                end
            end
            ST_FLUSH: begin
                hold_cnt_d = HoldLoad;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                // Exceptions here come from squashed wrong-path instructions.
                stall_c    = enc_stall;
                hold_cnt_d = hold_cnt_q - 4'd1;
                if (hold_cnt_q == 4'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= 4'd0;
            target_q   <= ZeroWord;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            target_q   <= target_d;
            flush_q    <= flush_d;
        end
    end

    // stall is forced low while reset is held so no stage freezes on stale requests.
    assign stall  = (rst == RstEnable) ? StallNone : stall_c;
    assign flush  = flush_q;
    assign new_pc = target_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall != StallNone) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_q && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// checked against a cycle-timestamp model of the flush/hold rules.
module tb_pipe_ctrl;

    localparam int          HOLD   = 3;
    localparam logic [31:0] VECTOR = 32'h0000_0020;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    int          m_stall_cnt;
    int          m_flush_cnt;
`endif

    int checks;
    int errors;

    // Model: cycle index, the cycle in which a flush is due, and the first
    // cycle in which a new exception may be taken.
    int          cyc;
    int          flush_cycle;
    int          accept_from;
    logic [31:0] exp_target;

    pipe_ctrl #(
        .EXC_VECTOR  (VECTOR),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of frozen stages grows with the depth of the requesting stage.
    function automatic logic [5:0] model_enc(input logic rif, input logic rid, input logic rex);
        int n;
        n = rex ? 4 : (rid ? 3 : (rif ? 2 : 0));
        return 6'((1 << n) - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] exc, input logic [31:0] epc,
                        input logic rif, input logic rid, input logic rex);
        logic [5:0] exp_stall;
        logic       exp_flush;
        @(negedge clk);
        excepttype_i = exc;
        cp0_epc_i    = epc;
        stallreq_if  = rif;
        stallreq_id  = rid;
        stallreq_ex  = rex;
        #1;
        if (cyc == flush_cycle) begin
            exp_stall = 6'b000000;
            exp_flush = 1'b1;
        end else begin
            exp_flush = 1'b0;
            if (cyc >= accept_from && exc != 32'h0) begin
                exp_stall   = 6'b111111;
                flush_cycle = cyc + 1;
                accept_from = cyc + 2 + HOLD;
                exp_target  = (exc == 32'h0000_000e) ? epc : VECTOR;
            end else begin
                exp_stall = model_enc(rif, rid, rex);
            end
        end
        check("stall", {26'b0, stall}, {26'b0, exp_stall});
        check("flush", {31'b0, flush}, {31'b0, exp_flush});
        if (exp_flush) check("new_pc", new_pc, exp_target);
`ifdef PIPE_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, m_stall_cnt);
        check("flush_cnt", {16'b0, flush_cnt}, m_flush_cnt);
        if (exp_stall != 6'b0) m_stall_cnt++;
        if (exp_flush) m_flush_cnt++;
`endif
        $display("cyc=%0d exc=%h req=%b%b%b stall=%b flush=%b new_pc=%h",
                 cyc, exc, rex, rid, rif, stall, flush, new_pc);
        cyc++;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        flush_cycle  = -1;
        accept_from  = 0;
        exp_target   = 32'h0;
`ifdef PIPE_CTRL_PERF_EN
        m_stall_cnt  = 0;
        m_flush_cnt  = 0;
`endif
        rst          = 1'b1;
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b1;
        excepttype_i = 32'h0;
        cp0_epc_i    = 32'h0;
        #2;
        check("rst_stall", {26'b0, stall}, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_new_pc", new_pc, 32'h0);
        stallreq_ex = 1'b0;
        #10;
        rst = 1'b0;

        // Stall priority encode
        step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Plain exception with a concurrent stall request, then idle through HOLD
        step(32'h1, 32'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // ERET redirects to EPC
        step(32'h0000_000e, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(32'h0, 32'h0, 1'b0, i[0], 1'b0);

        // Exception held across FLUSH and HOLD, then re-accepted in RUN
        for (int i = 0; i < 6; i++) step(32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while in HOLD with stallreq_ex asserted
        step(32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("arst_stall", {26'b0, stall}, 32'h0);
        check("arst_flush", {31'b0, flush}, 32'h0);
        check("arst_new_pc", new_pc, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        check("arst_stall_cnt", stall_cnt, 32'h0);
        check("arst_flush_cnt", {16'b0, flush_cnt}, 32'h0);
`endif
        #1 rst = 1'b0;
        flush_cycle = -1;
        accept_from = 0;
`ifdef PIPE_CTRL_PERF_EN
        // The edge right after release sees stallreq_ex in RUN.
        m_stall_cnt = 1;
        m_flush_cnt = 0;
`endif
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] exc;
            logic [31:0] epc;
            logic [2:0]  req;
            exc = 32'h0;
            if ($urandom_range(0, 4) == 0) begin
                exc = ($urandom_range(0, 2) == 0) ? 32'h0000_000e : ($urandom() | 32'h1);
            end
            epc = $urandom();
            req = 3'($urandom_range(0, 7));
            step(exc, epc, req[0], req[1], req[2]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
